// File: rtl/guvm_icache_pkg.sv
// Shared types and widths for the instruction-cache responder model.
package guvm_icache_pkg;

  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } icache_state_t;

endpackage

// File: rtl/guvm_word_ram.sv
// Instruction word store: synchronous write, asynchronous read, contents not reset.
module guvm_word_ram
  import guvm_icache_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Preload write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/guvm_icache_responder.sv
// Fetch-port responder: accepts a request, holds the core for LATENCY cycles,
// then returns the addressed word (or an exception) as a registered one-cycle pulse.
module guvm_icache_responder
  import guvm_icache_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [WORD_W-1:0]        load_data,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  input  logic                     req_flush,
  output logic [WORD_W-1:0]        resp_data,
  output logic                     resp_valid,
  output logic                     resp_hold,
  output logic                     resp_exception,
  output logic [15:0]              fetch_count
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);
  localparam logic [32:0]      SPAN     = 33'(DEPTH) * 33'd4;

  icache_state_t     state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] data_q;
  logic              valid_q, hold_q, exc_q;
  logic [15:0]       fcnt_q;

  logic [31:0]       look_addr_s;
  logic [32:0]       diff_s;
  logic              err_s;
  logic [IDX_W-1:0]  ram_idx_s;
  logic [WORD_W-1:0] ram_rdata_s;

  guvm_word_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk_i   (clk),
    .we_i    (load_en),
    .waddr_i (load_idx),
    .wdata_i (load_data),
    .raddr_i (ram_idx_s),
    .rdata_o (ram_rdata_s)
  );

  // Address decode; with zero latency the word is looked up straight from the request
  always_comb begin
    look_addr_s = (state_q == IDLE) ? req_addr : addr_q;
    diff_s      = {1'b0, look_addr_s} - {1'b0, BASE_ADDR};
    err_s       = (look_addr_s[1:0] != 2'b00) || diff_s[32] || (diff_s >= SPAN);
    ram_idx_s   = diff_s[IDX_W+1:2];
  end

  // Next-state logic for the request/wait/response sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !req_flush) begin
          addr_d  = req_addr;
          cnt_d   = LAT_INIT;
          state_d = (LAT_INIT == {LAT_W{1'b0}}) ? RESP : WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (req_flush) begin
          state_d = IDLE;
        end else if (cnt_q == LAT_W'(1)) begin
          cnt_d   = cnt_q - LAT_W'(1);
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q - LAT_W'(1);
        end
      end
      // Response registers are already committed once RESP is entered
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter and registered outputs; the response is captured on entry to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {LAT_W{1'b0}};
      addr_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      hold_q  <= 1'b1;
      exc_q   <= 1'b0;
      data_q  <= {WORD_W{1'b0}};
      fcnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= (state_d == RESP);
      hold_q  <= (state_d != WAIT);
      if (state_d == RESP) begin
        exc_q  <= err_s;
        data_q <= err_s ? {WORD_W{1'b0}} : ram_rdata_s;
        fcnt_q <= fcnt_q + 16'd1;
      end
    end
  end

  assign resp_data      = data_q;
  assign resp_valid     = valid_q;
  assign resp_hold      = hold_q;
  assign resp_exception = exc_q;
  assign fetch_count    = fcnt_q;

endmodule

// File: tb/tb_guvm_icache_responder.sv
// Directed bench for guvm_icache_responder: instance 0 uses LATENCY=2, instance 1 LATENCY=0.
module tb_guvm_icache_responder;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        ld_en   [2];
  logic [7:0]  ld_idx  [2];
  logic [31:0] ld_data [2];
  logic        rv      [2];
  logic [31:0] ra      [2];
  logic        rf      [2];
  logic [31:0] rd      [2];
  logic        rvld    [2];
  logic        rh      [2];
  logic        rx      [2];
  logic [15:0] fc      [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  guvm_icache_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .load_en(ld_en[0]), .load_idx(ld_idx[0]), .load_data(ld_data[0]),
    .req_valid(rv[0]), .req_addr(ra[0]), .req_flush(rf[0]), .resp_data(rd[0]),
    .resp_valid(rvld[0]), .resp_hold(rh[0]), .resp_exception(rx[0]), .fetch_count(fc[0])
  );

  guvm_icache_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .load_en(ld_en[1]), .load_idx(ld_idx[1]), .load_data(ld_data[1]),
    .req_valid(rv[1]), .req_addr(ra[1]), .req_flush(rf[1]), .resp_data(rd[1]),
    .resp_valid(rvld[1]), .resp_hold(rh[1]), .resp_exception(rx[1]), .fetch_count(fc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Transaction-level model: each accepted request owns the fetch port from its
  // sample cycle until cycle req+1+LAT, when the response appears.
  int          lat [2] = '{2, 0};
  int          cyc = 0;
  bit          busy    [2];
  int          resp_at [2];
  logic [31:0] maddr   [2];
  logic [31:0] mem     [2][DEPTH];
  logic        ev [2], eh [2], ex [2];
  logic [31:0] ed [2];
  logic [15:0] ecnt [2];

  always @(posedge clk) begin
    longint off;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy[k] = 1'b0;
        ev[k] = 1'b0; eh[k] = 1'b1; ex[k] = 1'b0; ed[k] = 32'h0; ecnt[k] = 16'h0;
      end else begin
        if (busy[k] && (cyc == resp_at[k] || rf[k])) begin
          busy[k] = 1'b0;
        end else if (!busy[k] && rv[k] && !rf[k]) begin
          busy[k]    = 1'b1;
          resp_at[k] = cyc + 1 + lat[k];
          maddr[k]   = ra[k];
        end
        ev[k] = busy[k] && (cyc + 1 == resp_at[k]);
        eh[k] = !(busy[k] && (cyc + 1 < resp_at[k]));
        if (ev[k]) begin
          off   = longint'(maddr[k]) - longint'(BASE);
          ex[k] = (maddr[k] % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
          ed[k] = ex[k] ? 32'h0 : mem[k][int'(off / 4)];
          ecnt[k] = ecnt[k] + 16'd1;
        end
      end
      if (ld_en[k]) mem[k][ld_idx[k]] = ld_data[k];
    end
    cyc++;
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("mdl_valid%0d", k), 32'(rvld[k]), 32'(ev[k]));
        chk($sformatf("mdl_hold%0d", k),  32'(rh[k]),   32'(eh[k]));
        chk($sformatf("mdl_exc%0d", k),   32'(rx[k]),   32'(ex[k]));
        chk($sformatf("mdl_data%0d", k),  rd[k],        ed[k]);
        chk($sformatf("mdl_count%0d", k), 32'(fc[k]),   32'(ecnt[k]));
      end
    end
  end

  logic [31:0] lit [4] = '{32'h8E00C002, 32'h01000000, 32'h82102005, 32'h81C3E008};

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ld_en[k] = 1'b0; ld_idx[k] = 8'h0; ld_data[k] = 32'h0;
      rv[k] = 1'b0; ra[k] = 32'h0; rf[k] = 1'b0;
    end
    tick(2);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(rvld[0]), 32'd0);
    chk("rst_hold", 32'(rh[0]), 32'd1);
    chk("rst_exc", 32'(rx[0]), 32'd0);
    chk("rst_data", rd[0], 32'h0);
    chk("rst_count", 32'(fc[0]), 32'd0);
    rst = 1'b0;

    // Preload every word; the first four carry the reference program
    for (int i = 0; i < DEPTH; i++) begin
      for (int k = 0; k < 2; k++) begin
        ld_en[k]   = 1'b1;
        ld_idx[k]  = 8'(i);
        ld_data[k] = (i < 4) ? lit[i] : (32'hA5000000 | 32'(i));
      end
      tick(1);
    end
    for (int k = 0; k < 2; k++) ld_en[k] = 1'b0;
    tick(1);

    // Four fetches with LATENCY=2
    for (int j = 0; j < 4; j++) begin
      rv[0] = 1'b1; ra[0] = 32'(j * 4);
      tick(1);
      rv[0] = 1'b0;
      @(negedge clk); chk("t1_hold_n1", 32'(rh[0]), 32'd0);
      chk("t1_novalid_n1", 32'(rvld[0]), 32'd0);
      tick(1);
      @(negedge clk); chk("t1_hold_n2", 32'(rh[0]), 32'd0);
      tick(1);
      @(negedge clk); chk("t1_valid_n3", 32'(rvld[0]), 32'd1);
      chk("t1_hold_n3", 32'(rh[0]), 32'd1);
      chk("t1_data", rd[0], lit[j]);
      tick(1);
    end
    chk("t1_count", 32'(fc[0]), 32'd4);

    // LATENCY=0 with a request held high: a response every second cycle
    rv[1] = 1'b1; ra[1] = 32'h4;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      @(negedge clk);
      chk("t2_valid", 32'(rvld[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_hold", 32'(rh[1]), 32'd1);
      if (i % 2 == 0) chk("t2_data", rd[1], 32'h01000000);
    end
    rv[1] = 1'b0;
    tick(2);
    rv[1] = 1'b1; rf[1] = 1'b1;
    tick(1);
    rv[1] = 1'b0; rf[1] = 1'b0;
    @(negedge clk);
    chk("t2_flush_idle_novalid", 32'(rvld[1]), 32'd0);
    chk("t2_flush_idle_count", 32'(fc[1]), 32'd3);
    tick(1);

    // Misaligned and out-of-range addresses
    rv[0] = 1'b1; ra[0] = 32'h6;
    tick(1); rv[0] = 1'b0; tick(2);
    @(negedge clk);
    chk("t3_mis_valid", 32'(rvld[0]), 32'd1);
    chk("t3_mis_exc", 32'(rx[0]), 32'd1);
    chk("t3_mis_data", rd[0], 32'h0);
    tick(1);
    rv[0] = 1'b1; ra[0] = 32'h400;
    tick(1); rv[0] = 1'b0; tick(2);
    @(negedge clk);
    chk("t3_oor_exc", 32'(rx[0]), 32'd1);
    chk("t3_oor_data", rd[0], 32'h0);
    tick(1);

    // Flush in the first WAIT cycle, then a normal fetch
    rv[0] = 1'b1; ra[0] = 32'h8;
    tick(1);
    rv[0] = 1'b0; rf[0] = 1'b1;
    tick(1);
    rf[0] = 1'b0;
    @(negedge clk);
    chk("t4_hold_after_flush", 32'(rh[0]), 32'd1);
    tick(3);
    @(negedge clk);
    chk("t4_novalid", 32'(rvld[0]), 32'd0);
    chk("t4_count", 32'(fc[0]), 32'd6);
    rv[0] = 1'b1; ra[0] = 32'hC;
    tick(1); rv[0] = 1'b0; tick(2);
    @(negedge clk);
    chk("t4_next_valid", 32'(rvld[0]), 32'd1);
    chk("t4_next_data", rd[0], 32'h81C3E008);
    chk("t4_next_exc", 32'(rx[0]), 32'd0);
    tick(1);

    // Load colliding with the RESP cycle returns the old word
    rv[0] = 1'b1; ra[0] = 32'h4;
    tick(1); rv[0] = 1'b0; tick(2);
    ld_en[0] = 1'b1; ld_idx[0] = 8'd1; ld_data[0] = 32'hDEADBEEF;
    @(negedge clk);
    chk("t5_old_word", rd[0], 32'h01000000);
    tick(1);
    ld_en[0] = 1'b0;
    rv[0] = 1'b1; ra[0] = 32'h4;
    tick(1); rv[0] = 1'b0; tick(2);
    @(negedge clk);
    chk("t5_new_word", rd[0], 32'hDEADBEEF);
    chk("t5_count", 32'(fc[0]), 32'd9);
    tick(1);

    // Reset during WAIT
    rv[0] = 1'b1; ra[0] = 32'h0;
    tick(1);
    rv[0] = 1'b0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_hold", 32'(rh[0]), 32'd1);
    chk("t6_valid", 32'(rvld[0]), 32'd0);
    chk("t6_count", 32'(fc[0]), 32'd0);
    tick(4);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
